// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
//   XLEN       - register data width
//   REG_ADDR_W - register index width
//   NUM_REGS   - number of architectural registers
//   wb_entry_t - one pending register write {id, data}
package wb_arb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] id;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous in-order FIFO holding long-latency results awaiting a free
// register-file write slot.
//   clk, rst   - clock, synchronous active-high reset
//   push, din  - enqueue din (ignored when full)
//   pop        - dequeue head (ignored when empty)
//   full/empty - occupancy flags
//   count      - occupancy, 0..DEPTH
//   head       - oldest entry (valid when !empty)
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_entry_t                  din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output wb_entry_t                  head
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset; entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// writeback stage (fixed priority) and buffered long-latency results, and
// tracks destinations with results still in flight.
//   clk, rst                    - clock, synchronous active-high reset
//   wb_en/wb_id/wb_data         - writeback stage write request
//   lu_valid/lu_ready/lu_id/... - long-latency result handshake
//   issue_en/issue_id           - long-latency op issued (marks dest busy)
//   rf_we/rf_waddr/rf_wdata     - registered register-file write port
//   busy_mask                   - per-register outstanding-result flags
//   stall_req                   - ask the pipeline to idle so the FIFO drains
//   q_count                     - FIFO occupancy
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN         = wb_arb_pkg::XLEN,
  parameter int REG_ADDR_W   = wb_arb_pkg::REG_ADDR_W,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_en,
  input  logic [REG_ADDR_W-1:0]      wb_id,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       lu_valid,
  output logic                       lu_ready,
  input  logic [REG_ADDR_W-1:0]      lu_id,
  input  logic [XLEN-1:0]            lu_data,
  input  logic                       issue_en,
  input  logic [REG_ADDR_W-1:0]      issue_id,
  output logic                       rf_we,
  output logic [REG_ADDR_W-1:0]      rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic [2**REG_ADDR_W-1:0]   busy_mask,
  output logic                       stall_req,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic             fifo_full, fifo_empty;
  logic             push, pop, wb_req;
  wb_entry_t        head, din;
  logic [AGE_W-1:0] age;
  logic [2**REG_ADDR_W-1:0] busy_nxt;

  // Writes to x0 are not real requests: they neither win the slot nor
  // occupy the FIFO.
  assign wb_req   = wb_en && (wb_id != '0);
  assign lu_ready = !rst && !fifo_full;
  assign push     = lu_valid && lu_ready && (lu_id != '0);
  assign pop      = !wb_req && !fifo_empty;
  assign din      = '{id: lu_id, data: lu_data};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count),
    .head  (head)
  );

  // Registered write port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wb_req || pop;
      if (wb_req) begin
        rf_waddr <= wb_id;
        rf_wdata <= wb_data;
      end else if (pop) begin
        rf_waddr <= head.id;
        rf_wdata <= head.data;
      end
    end
  end

  // Scoreboard: a new issue to a register overrides the retiring pop of
  // that same register, since it denotes a younger outstanding result.
  always_comb begin
    busy_nxt = busy_mask;
    if (pop) busy_nxt[head.id] = 1'b0;
    if (issue_en && (issue_id != '0)) busy_nxt[issue_id] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_mask <= '0;
    else     busy_mask <= busy_nxt;
  end

  // Starvation age: cycles the head has waited behind the writeback stage.
  always_ff @(posedge clk) begin
    if (rst || fifo_empty || pop)         age <= '0;
    else if (age != AGE_W'(STARVE_LIMIT)) age <= age + AGE_W'(1);
  end

  assign stall_req = fifo_full || (age == AGE_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_id;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_id;
  logic [31:0] lu_data;
  logic        issue_en;
  logic [4:0]  issue_id;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic        stall_req;
  logic [1:0]  q_count;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_en     (wb_en),
    .wb_id     (wb_id),
    .wb_data   (wb_data),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_id     (lu_id),
    .lu_data   (lu_data),
    .issue_en  (issue_en),
    .issue_id  (issue_id),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy_mask (busy_mask),
    .stall_req (stall_req),
    .q_count   (q_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Advance one edge, sample 1 time unit later; every write seen on the
  // port must match the oldest expected write.
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    if (rf_we === 1'b1) begin
      n_chk++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected_write: observed addr %0h data %0h expected no write", rf_waddr, rf_wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_addr", 64'(rf_waddr), 64'(e.addr));
        chk("sb_data", 64'(rf_wdata), 64'(e.data));
      end
    end
  endtask

  initial begin
    rst = 1'b1; wb_en = 0; wb_id = 0; wb_data = 0;
    lu_valid = 0; lu_id = 0; lu_data = 0; issue_en = 0; issue_id = 0;

    // Reset state
    step(); step();
    chk("rst_rf_we", 64'(rf_we), 0);
    chk("rst_q_count", 64'(q_count), 0);
    chk("rst_busy", 64'(busy_mask), 0);
    chk("rst_stall", 64'(stall_req), 0);
    chk("rst_lu_ready", 64'(lu_ready), 0);
    rst = 1'b0;
    #1;
    chk("lu_ready_after_rst", 64'(lu_ready), 1);

    // Plain writeback: one-cycle latency, then idle with held address
    wb_en = 1; wb_id = 5; wb_data = 32'hDEADBEEF;
    expect_wr(5, 32'hDEADBEEF);
    step();
    chk("wb_rf_we", 64'(rf_we), 1);
    wb_en = 0;
    step();
    chk("wb_idle_we", 64'(rf_we), 0);
    chk("wb_hold_addr", 64'(rf_waddr), 5);

    // Issue, result return, pop clears busy
    issue_en = 1; issue_id = 7;
    step();
    issue_en = 0;
    chk("busy7_set", 64'(busy_mask), 64'(32'h1 << 7));
    lu_valid = 1; lu_id = 7; lu_data = 32'h12;
    step();
    lu_valid = 0;
    chk("lu_enq_q", 64'(q_count), 1);
    chk("lu_enq_no_we", 64'(rf_we), 0);
    expect_wr(7, 32'h12);
    step();
    chk("lu_pop_we", 64'(rf_we), 1);
    chk("busy7_clr", 64'(busy_mask), 0);
    chk("lu_pop_q", 64'(q_count), 0);

    // Fill FIFO behind a busy writeback stage
    wb_en = 1; wb_id = 3; wb_data = 32'h301;
    lu_valid = 1; lu_id = 10; lu_data = 32'hA0;
    expect_wr(3, 32'h301);
    step();
    wb_data = 32'h302; lu_id = 11; lu_data = 32'hB0;
    expect_wr(3, 32'h302);
    step();
    chk("full_q", 64'(q_count), 2);
    chk("full_ready", 64'(lu_ready), 0);
    chk("full_stall", 64'(stall_req), 1);
    wb_data = 32'h303; lu_id = 12; lu_data = 32'hC0;
    expect_wr(3, 32'h303);
    step();
    chk("full_no_accept", 64'(q_count), 2);
    wb_en = 0; lu_valid = 0;
    expect_wr(10, 32'hA0);
    step();
    chk("drain1_q", 64'(q_count), 1);
    chk("drain1_stall", 64'(stall_req), 0);
    expect_wr(11, 32'hB0);
    step();
    chk("drain2_q", 64'(q_count), 0);
    step();
    chk("drain_idle_we", 64'(rf_we), 0);

    // Starvation: queued result waits behind writeback until age saturates
    wb_en = 1; wb_id = 3; lu_valid = 1; lu_id = 13; lu_data = 32'hD0;
    for (int k = 0; k < 5; k++) begin
      wb_data = 32'h400 + k;
      expect_wr(3, 32'h400 + k);
      step();
      lu_valid = 0;
      if (k == 3) chk("age3_stall", 64'(stall_req), 0);
    end
    chk("age4_stall", 64'(stall_req), 1);
    chk("age4_q", 64'(q_count), 1);
    wb_en = 0;
    expect_wr(13, 32'hD0);
    step();
    chk("starve_pop_q", 64'(q_count), 0);
    chk("starve_pop_stall", 64'(stall_req), 0);

    // x0 handling: neither source writes or enqueues register 0
    lu_valid = 1; lu_id = 0; lu_data = 32'h55;
    wb_en = 1; wb_id = 0; wb_data = 32'h66;
    step();
    lu_valid = 0; wb_en = 0;
    chk("x0_no_we", 64'(rf_we), 0);
    chk("x0_q", 64'(q_count), 0);
    chk("x0_busy", 64'(busy_mask), 0);

    // Same-edge issue and pop of register 9: set wins
    issue_en = 1; issue_id = 9;
    step();
    issue_en = 0;
    lu_valid = 1; lu_id = 9; lu_data = 32'h99;
    step();
    lu_valid = 0;
    chk("r9_q", 64'(q_count), 1);
    issue_en = 1; issue_id = 9;
    expect_wr(9, 32'h99);
    step();
    issue_en = 0;
    chk("r9_set_wins", 64'(busy_mask), 64'(32'h1 << 9));

    // Reset with two entries queued and busy bits set
    wb_en = 1; wb_id = 4; wb_data = 32'h501;
    lu_valid = 1; lu_id = 21; lu_data = 32'h21;
    issue_en = 1; issue_id = 20;
    expect_wr(4, 32'h501);
    step();
    issue_en = 0;
    wb_data = 32'h502; lu_id = 22; lu_data = 32'h22;
    expect_wr(4, 32'h502);
    step();
    chk("pre_rst_q", 64'(q_count), 2);
    chk("pre_rst_busy", 64'(busy_mask), 64'((32'h1 << 9) | (32'h1 << 20)));
    rst = 1; wb_en = 0; lu_valid = 1; lu_id = 23;
    #1;
    chk("rst_hi_ready", 64'(lu_ready), 0);
    step();
    lu_valid = 0;
    chk("mid_rst_q", 64'(q_count), 0);
    chk("mid_rst_busy", 64'(busy_mask), 0);
    chk("mid_rst_we", 64'(rf_we), 0);
    chk("mid_rst_stall", 64'(stall_req), 0);
    chk("mid_rst_ready", 64'(lu_ready), 0);
    rst = 0;
    step();
    chk("post_rst_we", 64'(rf_we), 0);
    chk("post_rst_q", 64'(q_count), 0);
    chk("sb_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
